// File: rtl/phys_reg_free_list_if.sv
// Rename/retire-facing signal bundle of the physical register free list.
// master = rename + ROB retire side, slave = the free list itself.
interface phys_reg_free_list_if #(
    parameter int PREG_W = 6
);
    logic              alloc_req;
    logic              alloc_valid;
    logic [PREG_W-1:0] alloc_preg;
    logic              free0_valid;
    logic [PREG_W-1:0] free0_preg;
    logic              free1_valid;
    logic [PREG_W-1:0] free1_preg;
    logic              stall;
    logic [PREG_W:0]   free_count;
    logic              overflow_err;
    logic              dup_err;

    modport master (
        output alloc_req, free0_valid, free0_preg, free1_valid, free1_preg,
        input  alloc_valid, alloc_preg, stall, free_count, overflow_err, dup_err
    );

    modport slave (
        input  alloc_req, free0_valid, free0_preg, free1_valid, free1_preg,
        output alloc_valid, alloc_preg, stall, free_count, overflow_err, dup_err
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Circular FIFO of free physical register tags: one allocation, two releases per cycle.
// Optional macro FREE_LIST_DUP_CHECK_EN adds an in-list bitmap that rejects duplicate releases.
module phys_reg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_AREGS = 32,
    parameter int PREG_W    = 6
) (
    input logic                 clk,
    input logic                 rstn,
    phys_reg_free_list_if.slave fl
);
    localparam logic [PREG_W:0] FULL = (PREG_W+1)'(NUM_PREGS);

    logic [PREG_W-1:0] mem [NUM_PREGS];
    logic [PREG_W-1:0] head;
    logic [PREG_W-1:0] tail;
    logic [PREG_W:0]   count;
    logic              overflow_q;

    logic              grant;
    logic [PREG_W:0]   cnt_after;
    logic [PREG_W:0]   cnt_mid;
    logic              elig0, elig1;
    logic              dup0, dup1;
    logic              acc0, acc1;
    logic              ovf0, ovf1;
    logic [PREG_W-1:0] tail1;

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] in_list;
    logic                 dup_q;
`endif

    assign fl.alloc_valid  = (count != '0);
    assign fl.alloc_preg   = mem[head];
    assign fl.stall        = (count == '0);
    assign fl.free_count   = count;
    assign fl.overflow_err = overflow_q;
`ifdef FREE_LIST_DUP_CHECK_EN
    assign fl.dup_err      = dup_q;
`else
    assign fl.dup_err      = 1'b0;
`endif

    // Fullness is judged after this cycle's allocation; slot 0 claims space before slot 1.
    always_comb begin
        grant     = fl.alloc_req && (count != '0);
        cnt_after = count - (PREG_W+1)'(grant);
        elig0     = fl.free0_valid && (fl.free0_preg != '0);
        elig1     = fl.free1_valid && (fl.free1_preg != '0);
`ifdef FREE_LIST_DUP_CHECK_EN
        dup0      = elig0 && in_list[fl.free0_preg];
        dup1      = elig1 && (in_list[fl.free1_preg] ||
                              (fl.free0_valid && (fl.free0_preg == fl.free1_preg)));
`else
        dup0      = 1'b0;
        dup1      = 1'b0;
`endif
        acc0      = elig0 && !dup0 && (cnt_after != FULL);
        ovf0      = elig0 && !dup0 && (cnt_after == FULL);
        cnt_mid   = cnt_after + (PREG_W+1)'(acc0);
        acc1      = elig1 && !dup1 && (cnt_mid != FULL);
        ovf1      = elig1 && !dup1 && (cnt_mid == FULL);
        tail1     = tail + PREG_W'(acc0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++) begin
                if (i < NUM_PREGS - NUM_AREGS)
                    mem[i] <= PREG_W'(NUM_AREGS + i);
                else
                    mem[i] <= '0;
            end
            head       <= '0;
            tail       <= PREG_W'(NUM_PREGS - NUM_AREGS);
            count      <= (PREG_W+1)'(NUM_PREGS - NUM_AREGS);
            overflow_q <= 1'b0;
        end else begin
            if (acc0)
                mem[tail] <= fl.free0_preg;
            if (acc1)
                mem[tail1] <= fl.free1_preg;
            head       <= head + PREG_W'(grant);
            tail       <= tail1 + PREG_W'(acc1);
            count      <= cnt_mid + (PREG_W+1)'(acc1);
            overflow_q <= overflow_q | ovf0 | ovf1;
        end
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_PREGS; i++)
                in_list[i] <= (i >= NUM_AREGS);
            dup_q <= 1'b0;
        end else begin
            // A release can never hit the head tag in the same cycle (it would be a dup),
            // so clear-then-set ordering cannot lose a bit.
            if (grant)
                in_list[mem[head]] <= 1'b0;
            if (acc0)
                in_list[fl.free0_preg] <= 1'b1;
            if (acc1)
                in_list[fl.free1_preg] <= 1'b1;
            dup_q <= dup_q | dup0 | dup1;
        end
    end
`endif
endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed bench for phys_reg_free_list with a queue-based reference model checked every cycle.
module tb_phys_reg_free_list;
    localparam int NP = 64;
    localparam int NA = 32;
    localparam int W  = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    phys_reg_free_list_if #(.PREG_W(W)) bus ();

    phys_reg_free_list #(.NUM_PREGS(NP), .NUM_AREGS(NA), .PREG_W(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .fl   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef FREE_LIST_DUP_CHECK_EN
    localparam bit DUP_EN = 1'b1;
`else
    localparam bit DUP_EN = 1'b0;
`endif

    // Reference model: a plain queue of tags plus a membership table.
    int unsigned q[$];
    bit          m_in[NP];
    bit          m_ovf;
    bit          m_dup;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            for (int i = NA; i < NP; i++) q.push_back(i);
            for (int i = 0; i < NP; i++) m_in[i] = (i >= NA);
            m_ovf = 0;
            m_dup = 0;
        end else begin
            bit          old_in[NP];
            bit          v[2];
            int unsigned t[2];
            old_in = m_in;
            v[0] = bus.free0_valid; t[0] = bus.free0_preg;
            v[1] = bus.free1_valid; t[1] = bus.free1_preg;
            if (bus.alloc_req && q.size() != 0) m_in[q.pop_front()] = 0;
            for (int s = 0; s < 2; s++) begin
                if (v[s] && t[s] != 0) begin
                    if (DUP_EN && (old_in[t[s]] || (s == 1 && v[0] && t[0] == t[1])))
                        m_dup = 1;
                    else if (q.size() >= NP)
                        m_ovf = 1;
                    else begin
                        q.push_back(t[s]);
                        m_in[t[s]] = 1;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_alloc_valid", int'(bus.alloc_valid), int'(q.size() != 0));
        check("model_stall", int'(bus.stall), int'(q.size() == 0));
        check("model_free_count", int'(bus.free_count), q.size());
        check("model_overflow_err", int'(bus.overflow_err), int'(m_ovf));
        check("model_dup_err", int'(bus.dup_err), int'(m_dup));
        if (q.size() != 0) check("model_alloc_preg", int'(bus.alloc_preg), int'(q[0]));
    end

    task automatic step(input bit ar, input bit v0, input int t0, input bit v1, input int t1);
        bus.alloc_req   = ar;
        bus.free0_valid = v0;
        bus.free0_preg  = W'(t0);
        bus.free1_valid = v1;
        bus.free1_preg  = W'(t1);
        @(posedge clk);
        #1;
        bus.alloc_req   = 1'b0;
        bus.free0_valid = 1'b0;
        bus.free1_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        #1;
        check("async_reset_count", int'(bus.free_count), 32);
        check("async_reset_preg", int'(bus.alloc_preg), 32);
        @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        bus.alloc_req = 0; bus.free0_valid = 0; bus.free0_preg = '0;
        bus.free1_valid = 0; bus.free1_preg = '0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("reset_alloc_preg", int'(bus.alloc_preg), 32);
        check("reset_free_count", int'(bus.free_count), 32);
        check("reset_stall", int'(bus.stall), 0);
        check("reset_alloc_valid", int'(bus.alloc_valid), 1);

        for (int i = 0; i < 32; i++) begin
            check("drain_order", int'(bus.alloc_preg), 32 + i);
            step(1, 0, 0, 0, 0);
        end
        check("empty_stall", int'(bus.stall), 1);
        check("empty_alloc_valid", int'(bus.alloc_valid), 0);
        check("empty_count", int'(bus.free_count), 0);
        step(1, 0, 0, 0, 0);
        check("empty_alloc_ignored", int'(bus.free_count), 0);

        step(0, 1, 5, 1, 9);
        check("dual_free_count", int'(bus.free_count), 2);
        check("dual_free_head", int'(bus.alloc_preg), 5);
        step(1, 0, 0, 0, 0);
        check("fifo_second", int'(bus.alloc_preg), 9);
        step(1, 0, 0, 0, 0);

        step(1, 1, 7, 0, 0);
        check("no_bypass_count", int'(bus.free_count), 1);
        check("no_bypass_valid", int'(bus.alloc_valid), 1);
        check("no_bypass_preg", int'(bus.alloc_preg), 7);
        step(1, 0, 0, 0, 0);

        step(0, 1, 0, 1, 12);
        check("p0_drop_count", int'(bus.free_count), 1);
        check("p0_drop_preg", int'(bus.alloc_preg), 12);
        check("p0_no_ovf", int'(bus.overflow_err), 0);
        check("p0_no_dup", int'(bus.dup_err), 0);

        do_reset();
        for (int i = 1; i < 31; i += 2) step(0, 1, i, 1, i + 1);
        step(0, 1, 31, 1, 33);
`ifndef FREE_LIST_DUP_CHECK_EN
        check("full_count", int'(bus.free_count), 64);
        step(0, 1, 40, 1, 41);
        check("full_drop_count", int'(bus.free_count), 64);
        check("full_overflow", int'(bus.overflow_err), 1);
        step(1, 1, 40, 1, 41);
        check("full_alloc_count", int'(bus.free_count), 64);
        check("full_alloc_head", int'(bus.alloc_preg), 33);
        for (int i = 0; i < 63; i++) step(1, 0, 0, 0, 0);
        check("full_slot0_tail", int'(bus.alloc_preg), 40);
        check("full_slot0_count", int'(bus.free_count), 1);
`else
        step(0, 1, 40, 1, 41);
        step(1, 1, 40, 1, 41);
        do_reset();
        step(0, 1, 40, 0, 0);
        check("dup_in_list_err", int'(bus.dup_err), 1);
        check("dup_in_list_count", int'(bus.free_count), 32);
        do_reset();
        step(1, 1, 15, 0, 0);
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
        check("dup_pre_count", int'(bus.free_count), 0);
        step(0, 1, 15, 1, 15);
        check("dup_pair_count", int'(bus.free_count), 1);
        check("dup_pair_err", int'(bus.dup_err), 1);
        check("dup_pair_preg", int'(bus.alloc_preg), 15);
`endif
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/phys_reg_free_list.md
Name: phys_reg_free_list

Overview:
- Circular free list of physical register tags, sitting between rename and the ROB retire path.
- Hands one free physical register per cycle to rename as the new dr.
- Accepts up to two released tags (old_dr of retired instructions) per cycle from ROB retire.
- Closes the allocate/release loop for the 64-entry physical register file; drives rename stall when exhausted.

Parameters:
- NUM_PREGS, 64, number of physical registers (power of two).
- NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset and never in the list at reset.
- PREG_W, 6, tag width, log2(NUM_PREGS).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- alloc_req  in  1  rename requests one tag this cycle.
- alloc_valid  out  1  a tag is available (count != 0).
- alloc_preg  out  PREG_W  tag at head; meaningful when alloc_valid.
- free0_valid  in  1  release slot 0 valid (ROB retire1).
- free0_preg  in  PREG_W  tag released on slot 0.
- free1_valid  in  1  release slot 1 valid (ROB retire2).
- free1_preg  in  PREG_W  tag released on slot 1.
- stall  out  1  high when count == 0; rename must hold.
- free_count  out  PREG_W+1  number of tags currently in list.
- overflow_err  out  1  sticky; a release was dropped because the list was full.
- dup_err  out  1  sticky; duplicate release detected (see Optional Feature).

Behaviour:
- Storage: NUM_PREGS x PREG_W array, head pointer, tail pointer (PREG_W bits, natural wrap NUM_PREGS-1 -> 0), count register (PREG_W+1 bits).
- Reset (async, rstn low): entry i = NUM_AREGS+i for i in 0..NUM_PREGS-NUM_AREGS-1; head=0; tail=NUM_PREGS-NUM_AREGS (32); count=32; overflow_err=0; dup_err=0. Outputs: alloc_valid=1, alloc_preg=32, stall=0, free_count=32.
- alloc_valid, alloc_preg, stall, free_count are combinational from registered state only; no input-to-output paths.
- Allocate: alloc_req && alloc_valid at a rising edge -> head+1. alloc_req while !alloc_valid is ignored; no state change.
- Release: each valid slot with tag != 0 is written at tail, slot 0 first then slot 1. Tail advances by the number accepted (0/1/2).
- p0 release (x0 mapping) is silently dropped and flags no error.
- Full: a release that would make count exceed NUM_PREGS is dropped and sets overflow_err. If count == NUM_PREGS-1 and both slots are valid, slot 0 is accepted and slot 1 is dropped.
- Simultaneous alloc + release: fullness is evaluated after the same-cycle allocation.
  - next count = count - granted_alloc + accepted_frees.
- No bypass: a tag released in cycle N is allocatable no earlier than cycle N+1, even if count was 0 in cycle N.
- Allocate ordering: strict FIFO; tags are handed out in release order.
- Sticky errors clear only on reset.
- Reset mid-operation: all in-flight requests are discarded and state returns to reset values immediately.

Optional Feature:
- FREE_LIST_DUP_CHECK_EN.
- Defined:
  - Adds a NUM_PREGS-bit in_list bitmap, reset to 1 for tags >= NUM_AREGS.
  - Allocation clears the head tag's bit; an accepted release sets its bit.
  - A release whose tag bit is already 1, or equal to the other slot's same-cycle tag, is dropped and sets dup_err. Slot 0 wins on an intra-cycle duplicate.
- Undefined: no bitmap; duplicates are pushed; dup_err tied 0.

Test Plan:
- Reset -> alloc_preg=32, free_count=32, stall=0; 32 back-to-back alloc_req -> tags 32..63 in order, then stall=1, alloc_valid=0, free_count=0.
- From empty: free0=5, free1=9 same cycle -> next cycle free_count=2, alloc_preg=5; after one alloc, alloc_preg=9.
- Empty list, alloc_req with free0=7 same cycle -> no grant that cycle, free_count=1; next cycle alloc_valid=1, alloc_preg=7.
- Full list (count=64) after reset plus frees of 1..31 and 33; free0=40 & free1=41 with no alloc -> both dropped, overflow_err=1; with alloc_req the same cycle at count=64, slot 0 is accepted and slot 1 is dropped.
- free0=0 with free1=12 -> only 12 enqueued, free_count +1, no error flags.
- With FREE_LIST_DUP_CHECK_EN: release 40 while still in list -> dropped, dup_err=1, free_count unchanged. Same-cycle free0=15, free1=15 after allocating 15 -> one copy enqueued, dup_err=1.
